// File: rtl/dragon_body_queue_if.sv
// Dragon body bus: frame/control inputs from game logic, queue state out to the renderer.
interface dragon_body_queue_if #(
  parameter int MAX_SEGMENTS = 16,
  parameter int POS_W        = 8,
  parameter int ORIENT_W     = 2
);
  localparam int SEG_W = ORIENT_W + POS_W;
  localparam int LEN_W = $clog2(MAX_SEGMENTS + 1);

  logic                          vsync;
  logic                          heal;
  logic                          hit;
  logic [SEG_W-1:0]              head;
  logic [MAX_SEGMENTS*SEG_W-1:0] segments;
  logic [MAX_SEGMENTS-1:0]       seg_en;
  logic [LEN_W-1:0]              length;
  logic                          step;
  logic                          dead;
  logic                          self_hit;

  modport slave (
    input  vsync, heal, hit, head,
    output segments, seg_en, length, step, dead, self_hit
  );

  modport master (
    output vsync, heal, hit, head,
    input  segments, seg_en, length, step, dead, self_hit
  );
endinterface

// File: rtl/dragon_body_queue.sv
// Dragon body shift queue: steps every MOVE_PERIOD frames, grows on heal, shrinks on
// cooldown-gated hits, and flags head-on-body collisions one cycle after they occur.
module dragon_body_queue #(
  parameter int               MAX_SEGMENTS    = 16,
  parameter int               POS_W           = 8,
  parameter int               ORIENT_W        = 2,
  parameter int               INIT_LEN        = 3,
  parameter int               MOVE_PERIOD     = 10,
  parameter int               COOLDOWN_CYCLES = 2**24,
  parameter logic [POS_W-1:0] EMPTY_POS       = 'hFB
) (
  input  logic                clk,
  input  logic                reset,
  dragon_body_queue_if.slave  bus
);
  localparam int SEG_W = ORIENT_W + POS_W;
  localparam int LEN_W = $clog2(MAX_SEGMENTS + 1);
  localparam int CD_W  = $clog2(COOLDOWN_CYCLES + 1);
  localparam int FC_W  = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
  localparam logic [SEG_W-1:0] EMPTY_SEG = {{ORIENT_W{1'b0}}, EMPTY_POS};

  function automatic logic [MAX_SEGMENTS-1:0] init_mask();
    logic [MAX_SEGMENTS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_SEGMENTS; i++)
      if (i < INIT_LEN) m[i] = 1'b1;
    return m;
  endfunction

  logic [SEG_W-1:0]        seg_q [MAX_SEGMENTS];
  logic [SEG_W-1:0]        seg_d [MAX_SEGMENTS];
  logic [MAX_SEGMENTS-1:0] seg_en_q, seg_en_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [FC_W-1:0]         frame_cnt_q, frame_cnt_d;
  logic [CD_W-1:0]         cooldown_q, cooldown_d;
  logic                    step_q, step_d;
  logic                    dead_q, dead_d;
  logic                    self_hit_q, self_hit_d;
  logic                    vsync_q, heal_q, hit_q;

  logic vs_rise, heal_e, hit_e, armed, roll;

  always_comb begin
    vs_rise = bus.vsync & ~vsync_q;
    heal_e  = bus.heal & ~heal_q;
    hit_e   = bus.hit & ~hit_q;
    // Queue stays unarmed until the first real head position has been shifted in.
    armed   = (seg_q[0][POS_W-1:0] != EMPTY_POS);
    roll    = vs_rise && (frame_cnt_q == FC_W'(MOVE_PERIOD - 1));
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (vs_rise) frame_cnt_d = roll ? '0 : frame_cnt_q + FC_W'(1);
    step_d = roll;

    for (int i = 0; i < MAX_SEGMENTS; i++) seg_d[i] = seg_q[i];
    if (roll) begin
      seg_d[0] = bus.head;
      for (int i = 1; i < MAX_SEGMENTS; i++) seg_d[i] = seg_q[i-1];
    end

    len_d      = len_q;
    seg_en_d   = seg_en_q;
    dead_d     = dead_q;
    cooldown_d = (cooldown_q != '0) ? cooldown_q - CD_W'(1) : '0;
    if (heal_e && armed && !dead_q) begin
      // A saturated heal still consumes a coincident hit.
      if (len_q != LEN_W'(MAX_SEGMENTS)) begin
        len_d    = len_q + LEN_W'(1);
        seg_en_d = {seg_en_q[MAX_SEGMENTS-2:0], 1'b1};
      end
    end else if (hit_e && armed && !dead_q && (cooldown_q == '0)) begin
      len_d      = len_q - LEN_W'(1);
      seg_en_d   = seg_en_q >> 1;
      cooldown_d = CD_W'(COOLDOWN_CYCLES - 1);
      if (len_q == LEN_W'(1)) dead_d = 1'b1;
    end

    self_hit_d = 1'b0;
    for (int i = 1; i < MAX_SEGMENTS; i++)
      if (seg_en_q[i] && (seg_q[i][POS_W-1:0] == bus.head[POS_W-1:0]) &&
          (bus.head[POS_W-1:0] != EMPTY_POS))
        self_hit_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < MAX_SEGMENTS; i++) seg_q[i] <= EMPTY_SEG;
      seg_en_q    <= init_mask();
      len_q       <= LEN_W'(INIT_LEN);
      frame_cnt_q <= '0;
      cooldown_q  <= '0;
      step_q      <= 1'b0;
      dead_q      <= 1'b0;
      self_hit_q  <= 1'b0;
      vsync_q     <= 1'b1;
      heal_q      <= 1'b1;
      hit_q       <= 1'b1;
    end else begin
      for (int i = 0; i < MAX_SEGMENTS; i++) seg_q[i] <= seg_d[i];
      seg_en_q    <= seg_en_d;
      len_q       <= len_d;
      frame_cnt_q <= frame_cnt_d;
      cooldown_q  <= cooldown_d;
      step_q      <= step_d;
      dead_q      <= dead_d;
      self_hit_q  <= self_hit_d;
      vsync_q     <= bus.vsync;
      heal_q      <= bus.heal;
      hit_q       <= bus.hit;
    end
  end

  logic [MAX_SEGMENTS*SEG_W-1:0] segs_flat;
  always_comb begin
    segs_flat = '0;
    for (int i = 0; i < MAX_SEGMENTS; i++) segs_flat[i*SEG_W +: SEG_W] = seg_q[i];
  end

  assign bus.segments = segs_flat;
  assign bus.seg_en   = seg_en_q;
  assign bus.length   = len_q;
  assign bus.step     = step_q;
  assign bus.dead     = dead_q;
  assign bus.self_hit = self_hit_q;
endmodule

// File: tb/tb_dragon_body_queue.sv
// Directed bench for dragon_body_queue: vector table for length/mask evolution plus
// hand sequences for step timing, reset edge history and self-hit latency.
module tb_dragon_body_queue;
  localparam int MAXS = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dragon_body_queue_if #(.MAX_SEGMENTS(MAXS), .POS_W(8), .ORIENT_W(2)) bus ();

  dragon_body_queue #(
    .MAX_SEGMENTS(MAXS), .POS_W(8), .ORIENT_W(2), .INIT_LEN(3),
    .MOVE_PERIOD(10), .COOLDOWN_CYCLES(100), .EMPTY_POS(8'hFB)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; bus.vsync = 1'b0; bus.heal = 1'b0; bus.hit = 1'b0; bus.head = 10'h000;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic vs_pulses(input int n, input logic [9:0] h);
    bus.head = h;
    repeat (n) begin
      bus.vsync = 1'b1; tick();
      bus.vsync = 1'b0; tick();
    end
  endtask

  task automatic pulse(input logic do_heal, input logic do_hit, input int n);
    repeat (n) begin
      bus.heal = do_heal; bus.hit = do_hit; tick();
      bus.heal = 1'b0;    bus.hit = 1'b0;   tick();
    end
  endtask

  function automatic logic [31:0] seg_at(input int i);
    return 32'(bus.segments[i*10 +: 10]);
  endfunction

  typedef enum int {OP_RESET, OP_VS, OP_HEAL, OP_HIT, OP_HEALHIT, OP_WAIT} op_e;
  typedef struct {
    op_e         op;
    int          n;
    logic [9:0]  head;
    int          exp_len;
    logic [15:0] exp_en;
    logic        exp_dead;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; bus.vsync = 1'b0; bus.heal = 1'b0; bus.hit = 1'b0; bus.head = 10'h000;

    // Hit spacing: hit edges at relative cycles 0, 50 (in cooldown) and 120 (accepted).
    vecs.push_back('{OP_RESET,   1, 10'h025,  3, 16'h0007, 1'b0});
    vecs.push_back('{OP_HEAL,    1, 10'h025,  3, 16'h0007, 1'b0});
    vecs.push_back('{OP_VS,     10, 10'h025,  3, 16'h0007, 1'b0});
    vecs.push_back('{OP_HEAL,    1, 10'h025,  4, 16'h000F, 1'b0});
    vecs.push_back('{OP_HEAL,   12, 10'h025, 16, 16'hFFFF, 1'b0});
    vecs.push_back('{OP_HEAL,    1, 10'h025, 16, 16'hFFFF, 1'b0});
    vecs.push_back('{OP_RESET,   1, 10'h025,  3, 16'h0007, 1'b0});
    vecs.push_back('{OP_VS,     10, 10'h025,  3, 16'h0007, 1'b0});
    vecs.push_back('{OP_HIT,     1, 10'h025,  2, 16'h0003, 1'b0});
    vecs.push_back('{OP_WAIT,   48, 10'h025,  2, 16'h0003, 1'b0});
    vecs.push_back('{OP_HIT,     1, 10'h025,  2, 16'h0003, 1'b0});
    vecs.push_back('{OP_WAIT,   68, 10'h025,  2, 16'h0003, 1'b0});
    vecs.push_back('{OP_HIT,     1, 10'h025,  1, 16'h0001, 1'b0});
    vecs.push_back('{OP_WAIT,  110, 10'h025,  1, 16'h0001, 1'b0});
    vecs.push_back('{OP_HEAL,    2, 10'h025,  3, 16'h0007, 1'b0});
    vecs.push_back('{OP_HEALHIT, 1, 10'h025,  4, 16'h000F, 1'b0});
    vecs.push_back('{OP_HIT,     1, 10'h025,  3, 16'h0007, 1'b0});
    vecs.push_back('{OP_WAIT,  110, 10'h025,  3, 16'h0007, 1'b0});
    vecs.push_back('{OP_HIT,     1, 10'h025,  2, 16'h0003, 1'b0});
    vecs.push_back('{OP_WAIT,  110, 10'h025,  2, 16'h0003, 1'b0});
    vecs.push_back('{OP_HIT,     1, 10'h025,  1, 16'h0001, 1'b0});
    vecs.push_back('{OP_WAIT,  110, 10'h025,  1, 16'h0001, 1'b0});
    vecs.push_back('{OP_HIT,     1, 10'h025,  0, 16'h0000, 1'b1});
    vecs.push_back('{OP_HEAL,    1, 10'h025,  0, 16'h0000, 1'b1});
    vecs.push_back('{OP_VS,     10, 10'h025,  0, 16'h0000, 1'b1});
    vecs.push_back('{OP_RESET,   1, 10'h025,  3, 16'h0007, 1'b0});

    for (int k = 0; k < vecs.size(); k++) begin
      case (vecs[k].op)
        OP_RESET:   do_reset();
        OP_VS:      vs_pulses(vecs[k].n, vecs[k].head);
        OP_HEAL:    pulse(1'b1, 1'b0, vecs[k].n);
        OP_HIT:     pulse(1'b0, 1'b1, vecs[k].n);
        OP_HEALHIT: pulse(1'b1, 1'b1, vecs[k].n);
        default:    repeat (vecs[k].n) tick();
      endcase
      check($sformatf("vec%0d length", k), 32'(bus.length), 32'(vecs[k].exp_len));
      check($sformatf("vec%0d seg_en", k), 32'(bus.seg_en), 32'(vecs[k].exp_en));
      check($sformatf("vec%0d dead", k),   32'(bus.dead),   32'(vecs[k].exp_dead));
    end

    // Reset with vsync held high: edge history must suppress a spurious rise.
    reset = 1'b0; bus.vsync = 1'b1; bus.heal = 1'b0; bus.hit = 1'b0; bus.head = 10'h025;
    repeat (2) tick();
    check("rst length", 32'(bus.length), 32'd3);
    check("rst seg_en", 32'(bus.seg_en), 32'h7);
    check("rst step", 32'(bus.step), 32'd0);
    check("rst dead", 32'(bus.dead), 32'd0);
    check("rst self_hit", 32'(bus.self_hit), 32'd0);
    for (int i = 0; i < MAXS; i++) check($sformatf("rst seg%0d", i), seg_at(i), 32'h0FB);
    reset = 1'b1; tick();
    check("post-rst step", 32'(bus.step), 32'd0);
    bus.vsync = 1'b0; tick();
    for (int p = 0; p < 20; p++) begin
      logic s_hi, s_lo;
      bus.vsync = 1'b1; tick(); s_hi = bus.step;
      bus.vsync = 1'b0; tick(); s_lo = bus.step;
      check($sformatf("step pulse%0d", p + 1), {30'd0, s_hi, s_lo},
            (p == 9 || p == 19) ? 32'h2 : 32'h0);
    end
    check("walk seg0", seg_at(0), 32'h025);
    check("walk seg1", seg_at(1), 32'h025);
    check("walk seg2", seg_at(2), 32'h0FB);
    check("walk seg_en", 32'(bus.seg_en), 32'h7);
    check("walk length", 32'(bus.length), 32'd3);

    // Self-hit: build body 041,030,025 then steer the head onto it.
    do_reset();
    vs_pulses(10, 10'h025);
    vs_pulses(10, 10'h030);
    vs_pulses(10, 10'h041);
    check("sh seg2", seg_at(2), 32'h025);
    check("sh seg0 excluded", 32'(bus.self_hit), 32'd0);
    bus.head = 10'h125;
    check("sh before edge", 32'(bus.self_hit), 32'd0);
    tick();
    check("sh seg2 hit", 32'(bus.self_hit), 32'd1);
    bus.head = 10'h130; tick();
    check("sh seg1 hit", 32'(bus.self_hit), 32'd1);
    bus.head = 10'h077; tick();
    check("sh clear", 32'(bus.self_hit), 32'd0);
    pulse(1'b0, 1'b1, 1);
    check("sh shrunk len", 32'(bus.length), 32'd2);
    bus.head = 10'h025; tick();
    check("sh masked seg2", 32'(bus.self_hit), 32'd0);
    bus.head = 10'h030; tick();
    check("sh seg1 still", 32'(bus.self_hit), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
